// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and status flag bit positions shared by the ALU pipeline.
package alu_pkg;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ANDN, OP_SHL, OP_PASSB
    } op_e;
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation-in and result-out handshakes of the ALU pipeline.
interface alu_pipe_if #(parameter int WIDTH = 8);
    import alu_pkg::*;
    logic             in_valid;
    logic             in_ready;
    op_e              op;
    logic             use_acc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic [WIDTH-1:0] acc;
    modport master (
        output in_valid, op, use_acc, a, b, out_ready,
        input  in_ready, out_valid, result, flags, acc
    );
    modport slave (
        input  in_valid, op, use_acc, a, b, out_ready,
        output in_ready, out_valid, result, flags, acc
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing the result and {v, c, n, z} flags.
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int SW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;
    logic [WIDTH:0] shl;
    logic           c;
    logic           v;
    assign sum = {1'b0, x} + {1'b0, b};
    assign dif = {1'b0, x} - {1'b0, b};
    // the last bit shifted out always lands in bit WIDTH because the amount is below WIDTH
    assign shl = {1'b0, x} << b[SW-1:0];
    always_comb begin
        result = b;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[MSB:0];
                c = sum[WIDTH];
                v = (x[MSB] == b[MSB]) && (sum[MSB] != x[MSB]);
            end
            OP_SUB: begin
                result = dif[MSB:0];
                c = dif[WIDTH];
                v = (x[MSB] != b[MSB]) && (dif[MSB] != x[MSB]);
            end
            OP_AND:   result = x & b;
            OP_OR:    result = x | b;
            OP_XOR:   result = x ^ b;
            OP_ANDN:  result = x & ~b;
            OP_SHL: begin
                result = shl[MSB:0];
                c = shl[WIDTH];
            end
            OP_PASSB: result = b;
        endcase
        flags = '0;
        flags[FLG_Z] = ~|result;
        flags[FLG_N] = result[MSB];
        flags[FLG_C] = c;
        flags[FLG_V] = v;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline with accumulator and registered flags.
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    alu_pipe_if.slave  bus
);
    logic             s1_valid_q, s1_valid_d;
    op_e              s1_op_q, s1_op_d;
    logic             s1_use_acc_q, s1_use_acc_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic             accept;
    logic             move;
    assign bus.in_ready = !reset && (!s1_valid_q || !s2_valid_q || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;
    assign move = s1_valid_q && (!s2_valid_q || bus.out_ready);
    // acc is written on the move of a use_acc entry, so the next entry already sees it here
    assign x = s1_use_acc_q ? acc_q : s1_a_q;
    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (s1_op_q),
        .x      (x),
        .b      (s1_b_q),
        .result (alu_res),
        .flags  (alu_flags)
    );
    always_comb begin
        s1_valid_d = accept || (s1_valid_q && !move);
        s1_op_d = accept ? bus.op : s1_op_q;
        s1_use_acc_d = accept ? bus.use_acc : s1_use_acc_q;
        s1_a_d = accept ? bus.a : s1_a_q;
        s1_b_d = accept ? bus.b : s1_b_q;
        s2_valid_d = move || (s2_valid_q && !bus.out_ready);
        result_d = move ? alu_res : result_q;
        flags_d = move ? alu_flags : flags_q;
        acc_d = (move && s1_use_acc_q) ? alu_res : acc_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q <= OP_ADD;
            s1_use_acc_q <= 1'b0;
            s1_a_q <= '0;
            s1_b_q <= '0;
            s2_valid_q <= 1'b0;
            result_q <= '0;
            flags_q <= '0;
            acc_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q <= s1_op_d;
            s1_use_acc_q <= s1_use_acc_d;
            s1_a_q <= s1_a_d;
            s1_b_q <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            result_q <= result_d;
            flags_q <= flags_d;
            acc_q <= acc_d;
        end
    end
    assign bus.out_valid = s2_valid_q;
    assign bus.result = result_q;
    assign bus.flags = flags_q;
    assign bus.acc = acc_q;
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined ALU with valid/ready handshakes on both sides, an internal accumulator, and registered status flags. It is a sequential benchmark circuit for the team's logic-optimisation and equivalence flows. WIDTH scales the datapath. Back-pressure and the accumulator give it real state beyond a single delay register.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2 to 64, must be a power of two.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  operation offered.
- in_ready  out  1  stage 1 can accept; forced 0 while reset is high.
- op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ANDN, 6 SHL, 7 PASSB.
- use_acc  in  1  replace operand a with the accumulator value.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- flags  out  4  registered {v, c, n, z}, bit 0 = z.
- acc  out  WIDTH  current accumulator contents.

## Operation
- Two pipeline registers, S1 and S2, each holding one entry with a valid bit.
- An input transfer happens when in_valid && in_ready. S1 captures op, use_acc, a and b.
- Compute happens on the S1→S2 move. The operand is acc when use_acc is set in S1, otherwise a.
- ADD: x+b. c is the carry out. v is signed overflow.
- SUB: x−b. c is the borrow (x<b unsigned). v is signed overflow.
- AND, OR, XOR: bitwise. ANDN is x & ~b. PASSB returns b. For all of these, c=0 and v=0.
- SHL: x shifted left by b[log2(WIDTH)−1:0], zero fill. c is the last bit shifted out; c=0 when the amount is 0. v=0.
- z = (result==0). n = result[WIDTH−1]. Both apply to every op.
- Accumulator loads the computed result on the S1→S2 move, only when that entry has use_acc=1.
- Ops with use_acc=0 never modify acc.
- Back-to-back use_acc ops are hazard-free. acc is written before the next entry can be computed.
- Arithmetic is modulo 2^WIDTH. Only the flags expose carry and overflow.

## Timing
- Reset values: S1/S2 valid=0, result=0, flags=0, acc=0, out_valid=0.
- After reset deasserts, in_ready=1.
- Latency: an entry accepted at edge k presents out_valid=1 with its result after edge k+1, when there is no stall.
- Throughput is one op per cycle while out_ready=1.
- in_ready = !S1.valid || !S2.valid || out_ready. This is combinational, with no other paths from in_valid.
- S2 advance: S2 is freed when out_valid && out_ready. S1 moves into S2 in the same edge.
- Stall: with out_ready=0 and both stages full, in_ready=0.
- During a stall, result, flags and acc hold stable.
- The pipeline holds at most 2 entries; no entry is dropped or duplicated.
- Simultaneous accept and drain in the same cycle: both occur, and occupancy is unchanged.
- in_valid without in_ready has no effect. Operands may change freely until the transfer.
- Reset mid-operation: in-flight entries are discarded and acc returns to 0 immediately (asynchronous).

## Structure
- Shared package alu_pkg holds:
  - the opcode enum (OP_ADD … OP_PASSB);
  - flag bit indices (FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3).
- One combinational sub-module, alu_core. Parameter WIDTH; ports op, x, b, result and flags.
- alu_pipe owns the S1/S2 registers, the handshake logic and the accumulator.

## Test plan
- WIDTH=8, reset, then ADD a=0x7F b=0x01 with out_ready=1 → two edges later result=0x80, flags v=1, n=1, c=0, z=0.
- SUB a=0x05 b=0x05 → result=0x00, z=1, c=0. Then SUB a=0x03 b=0x05 → result=0xFE, c=1, n=1.
- SHL a=0x81 b=0x01 → result=0x02, c=1. SHL with b=0x08 (amount field 0) → result=a, c=0.
- Accumulator: ADD use_acc b=0x03 three times back-to-back from reset → results 0x03, 0x06, 0x09, acc=0x09. An interleaved XOR with use_acc=0 leaves acc unchanged.
- Back-pressure: hold out_ready=0, offer 3 ops → the first 2 are accepted and in_ready=0 on the third. Release out_ready → all 3 emerge in order, with result stable while stalled.
- Assert reset with both stages full and acc=0x09 → out_valid=0, acc=0, flags=0 immediately. After release, in_ready=1.
